// File: rtl/cnn_kernel_acc_pipe.sv
// -----------------------------------------------------------------------------
// cnn_kernel_acc_pipe
//   Multiplies one KX*KY fmap window by KX*KY weights, reduces the products
//   through a fully registered adder tree, then accumulates the kernel sums
//   across input-channel beats framed by first/last flags.
//
//   Pipeline: 1 multiply stage, N_LVL tree stages, 1 channel-accumulate stage
//   (LATENCY = N_LVL+2 from i_in_valid to o_ot_valid).
//
// Ports:
//   clk               rising-edge clock
//   reset             synchronous active-high reset
//   i_soft_reset      synchronous pipeline flush (same effect as reset)
//   i_cnn_weight      KX*KY weights, element k at [k*W_BW +: W_BW]
//   i_in_valid        beat valid
//   i_in_first        first channel beat of an output point
//   i_in_last         last channel beat of an output point
//   i_in_fmap         KX*KY window, element k at [k*I_F_BW +: I_F_BW]
//   o_ot_kernel_valid per-beat kernel sum valid (N_LVL+1 cycles after input)
//   o_ot_kernel_acc   per-beat kernel sum
//   o_ot_valid        channel-accumulated point valid, 1-cycle pulse
//   o_ot_acc          channel-accumulated point
//
// Build option:
//   CNN_KERNEL_RELU_EN  when defined and SIGNED=1, negative points are output
//                       as 0 (internal accumulator keeps the raw value).
// -----------------------------------------------------------------------------
module cnn_kernel_acc_pipe #(
  parameter int KX     = 3,
  parameter int KY     = 3,
  parameter int I_F_BW = 8,
  parameter int W_BW   = 8,
  parameter int ICH    = 4,
  parameter int SIGNED = 0,
  localparam int M_BW    = I_F_BW + W_BW,
  localparam int N_LVL   = $clog2(KX * KY),
  localparam int AK_BW   = M_BW + N_LVL,
  localparam int AO_BW   = AK_BW + $clog2(ICH),
  localparam int LATENCY = N_LVL + 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_soft_reset,
  input  logic [KX*KY*W_BW-1:0]    i_cnn_weight,
  input  logic                     i_in_valid,
  input  logic                     i_in_first,
  input  logic                     i_in_last,
  input  logic [KX*KY*I_F_BW-1:0]  i_in_fmap,
  output logic                     o_ot_kernel_valid,
  output logic [AK_BW-1:0]         o_ot_kernel_acc,
  output logic                     o_ot_valid,
  output logic [AO_BW-1:0]         o_ot_acc
);

  localparam int NK = KX * KY;

  // Number of nodes at tree level l (level 0 = products).
  function automatic int lvl_cnt(input int l);
    int n;
    n = NK;
    for (int j = 0; j < l; j++) n = (n + 1) / 2;
    return n;
  endfunction

  // Product of one fmap/weight pair, extended to the tree width.
  function automatic logic signed [AK_BW-1:0] mul_ext(input logic [I_F_BW-1:0] a,
                                                      input logic [W_BW-1:0]   b);
    logic signed [M_BW-1:0]  ax;
    logic signed [M_BW-1:0]  bx;
    logic signed [M_BW-1:0]  p;
    logic signed [AK_BW-1:0] r;
    ax = {{W_BW{(SIGNED != 0) & a[I_F_BW-1]}}, a};
    bx = {{I_F_BW{(SIGNED != 0) & b[W_BW-1]}}, b};
    p  = ax * bx;
    r  = {AK_BW{(SIGNED != 0) & p[M_BW-1]}};
    r[M_BW-1:0] = p;
    return r;
  endfunction

  // Kernel sum extended to the accumulator width.
  function automatic logic signed [AO_BW-1:0] ext_ao(input logic signed [AK_BW-1:0] v);
    logic signed [AO_BW-1:0] r;
    r = {AO_BW{(SIGNED != 0) & v[AK_BW-1]}};
    r[AK_BW-1:0] = v;
    return r;
  endfunction

  // Output clamp; only negative values exist when SIGNED=1.
  function automatic logic [AO_BW-1:0] relu(input logic signed [AO_BW-1:0] v);
`ifdef CNN_KERNEL_RELU_EN
    if ((SIGNED != 0) && v[AO_BW-1]) return '0;
    else return v;
`else
    return v;
`endif
  endfunction

  logic                    flush;
  logic [N_LVL:0]          vld_p;
  logic [N_LVL:0]          first_p;
  logic [N_LVL:0]          last_p;
  logic signed [AK_BW-1:0] lvl_p [0:N_LVL][0:NK-1];
  logic signed [AO_BW-1:0] acc_p;
  logic signed [AO_BW-1:0] acc_nxt;

  assign flush = reset | i_soft_reset;

  // Control pipeline: bit 0 = product stage, bit l = tree level l.
  // Flags are qualified by valid so bubbles carry no framing.
  always_ff @(posedge clk) begin
    if (flush) begin
      vld_p   <= '0;
      first_p <= '0;
      last_p  <= '0;
    end else begin
      vld_p   <= {vld_p[N_LVL-1:0], i_in_valid};
      first_p <= {first_p[N_LVL-1:0], i_in_valid & i_in_first};
      last_p  <= {last_p[N_LVL-1:0], i_in_valid & i_in_last};
    end
  end

  // ---- stage 1: multiply ----
  always_ff @(posedge clk) begin
    if (i_in_valid) begin
      for (int k = 0; k < NK; k++)
        lvl_p[0][k] <= mul_ext(i_in_fmap[k*I_F_BW +: I_F_BW], i_cnn_weight[k*W_BW +: W_BW]);
    end
  end

  // ---- stages 2..N_LVL+1: adder tree ----
  // The final level is the visible kernel sum, so only it is cleared on flush.
  for (genvar l = 0; l < N_LVL; l++) begin : g_lvl
    localparam int NI = lvl_cnt(l);
    localparam int NO = lvl_cnt(l + 1);
    for (genvar i = 0; i < NO; i++) begin : g_node
      if (2 * i + 1 < NI) begin : g_add
        always_ff @(posedge clk) begin
          if ((l == N_LVL - 1) && flush) lvl_p[l+1][i] <= '0;
          else if (vld_p[l])             lvl_p[l+1][i] <= lvl_p[l][2*i] + lvl_p[l][2*i+1];
        end
      end else begin : g_pass
        always_ff @(posedge clk) begin
          if ((l == N_LVL - 1) && flush) lvl_p[l+1][i] <= '0;
          else if (vld_p[l])             lvl_p[l+1][i] <= lvl_p[l][2*i];
        end
      end
    end
  end

  assign o_ot_kernel_valid = vld_p[N_LVL];
  assign o_ot_kernel_acc   = lvl_p[N_LVL][0];

  // ---- stage LATENCY: channel accumulate ----
  // A first beat loads, discarding any unfinished partial sum.
  always_comb begin
    acc_nxt = acc_p + ext_ao(lvl_p[N_LVL][0]);
    if (first_p[N_LVL]) acc_nxt = ext_ao(lvl_p[N_LVL][0]);
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      acc_p      <= '0;
      o_ot_valid <= 1'b0;
      o_ot_acc   <= '0;
    end else begin
      o_ot_valid <= vld_p[N_LVL] & last_p[N_LVL];
      if (vld_p[N_LVL]) begin
        acc_p <= acc_nxt;
        if (last_p[N_LVL]) o_ot_acc <= relu(acc_nxt);
      end
    end
  end

endmodule
